bsg_link_delay_calib_ctrl: RTL and testbench
============================================

// Module: bsg_link_delay_calib_ctrl
// PURPOSE
//  Calibration sequencer for the per-bit 2-bit delay selects of the link delay line.
//  Sweeps every tap for all bits in parallel and checks sampled training data against the expected pattern.
//  Picks, per bit, the centre of the longest passing tap window and drives the final selects.
//  Sits beside the link receiver; sel_o feeds the tag-master wrapper that programs the delay-line tag clients.
// PARAMETERS
//  width_p          18  bits under calibration (2 + bsg_link_channel_width_gp)
//  sel_width_p      2   select bits per delay line; T = 2**sel_width_p taps
//  settle_cycles_p  16  cycles waited after each tap change before checking
//  check_cycles_p   64  compare cycles per tap
// PORTS
//  clk_i            in   1                    clock
//  reset_n_i        in   1                    synchronous, active-low reset
//  start_i          in   1                    start calibration; honoured only in IDLE/DONE
//  sample_i         in   width_p              received data after delay line
//  expected_i       in   width_p              cycle-aligned expected training pattern
//  override_v_i     in   1                    manual select write; honoured only in IDLE/DONE
//  override_sel_i   in   width_p*sel_width_p  manual select values, bit k at [k*sel_width_p+:sel_width_p]
//  sel_o            out  width_p*sel_width_p  delay select per bit, same packing
//  busy_o           out  1                    calibration in progress
//  done_o           out  1                    calibration complete, sel_o valid
//  fail_o           out  width_p              bit k had no passing tap
// BEHAVIOUR
//  Reset (reset_n_i==0 at an edge, any state, incl. mid-sweep):
//   - state IDLE; sel_o=0; busy_o=0; done_o=0; fail_o=0.
//  FSM states: IDLE, SETTLE, CHECK, ANALYZE, APPLY, DONE.
//  IDLE/DONE:
//   - start_i -> SETTLE: tap=0, sel_o=all 0, pass[k][t]=1 for all k,t, done_o=0, fail_o=0.
//   - start_i has priority over override_v_i in the same cycle.
//   - Otherwise override_v_i loads sel_o<=override_sel_i; state and done_o unchanged.
//   - start_i in any other state is ignored; no queueing.
//  SETTLE: counts settle_cycles_p cycles; compares ignored; then -> CHECK.
//  CHECK: check_cycles_p cycles.
//   - Each cycle, any k with sample_i[k]!=expected_i[k] clears pass[k][tap]; sticky.
//   - After the last cycle: if tap==T-1 -> ANALYZE; else tap++, all sel_o=tap, -> SETTLE.
//  ANALYZE: T cycles, one tap per cycle, t=0..T-1 ascending. Per bit, track:
//   - current run start/len: pass extends the run, fail resets len=0.
//   - best start/len: replaced only on strictly greater len (ties keep earliest run).
//  APPLY (1 cycle), per bit:
//   - best len>0: sel=best_start+((best_len-1)>>1) (floor centre), fail_o[k]=0.
//   - best len==0: sel=0, fail_o[k]=1.
//   - Then -> DONE.
//  DONE: done_o=1, sel_o/fail_o held until next start_i, override, or reset.
//  Flags: busy_o=1 in SETTLE/CHECK/ANALYZE/APPLY; done_o=1 only in DONE. Both registered.
//  Latency: start_i accepted at edge 0 -> done_o first high after edge 1+T*(S+C)+T+1.
//   - Defaults: edge 326.
//  Counters: sized to clog2 of their max; tap counter never wraps (terminal at T-1).
//  sel_o changes only at tap steps, APPLY, start, override, or reset; glitch-free (registered).
// TESTING
//  1 Reset: hold reset_n_i=0 mid-CHECK, release
//    -> sel_o=0, busy_o=0, done_o=0, fail_o=0, state IDLE; start then runs normally.
//  2 sample_i==expected_i always, start_i pulse
//    -> done_o rises at cycle 326; every sel=1 (window 0..3); fail_o=0.
//  3 Bit5 mismatches at taps 0,3; bit7 passes only tap 3; others clean
//    -> sel[5]=1, sel[7]=3, rest 1; fail_o=0.
//  4 Bit2 mismatches every tap; bit0 passes taps 0 and 2 only
//    -> fail_o=18'h4, sel[2]=0; sel[0]=0 (tie, earliest).
//  5 Single mismatch on bit9 in last CHECK cycle of tap 1, none in SETTLE
//    -> tap1 fails: window 2..3, sel[9]=2. Mismatches only in SETTLE are ignored: sel[9]=1.
//  6 start_i pulsed mid-sweep -> ignored, done at original cycle.
//    In DONE, override_v_i with all sel=3 -> sel_o=all 3, done_o stays 1.
//    start_i+override_v_i same cycle -> new sweep, sel_o=0.

Source files
------------

// File: rtl/bsg_link_delay_calib_ctrl.sv
// Per-bit delay-line calibration sequencer: sweeps every tap, records pass/fail per bit,
// then drives each bit's select to the floor centre of its longest passing tap window.
module bsg_link_delay_calib_ctrl #(
  parameter int width_p         = 18,
  parameter int sel_width_p     = 2,
  parameter int settle_cycles_p = 16,
  parameter int check_cycles_p  = 64
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           start_i,
  input  logic [width_p-1:0]             sample_i,
  input  logic [width_p-1:0]             expected_i,
  input  logic                           override_v_i,
  input  logic [width_p*sel_width_p-1:0] override_sel_i,
  output logic [width_p*sel_width_p-1:0] sel_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [width_p-1:0]             fail_o
);

  localparam int taps_lp    = 1 << sel_width_p;
  localparam int cnt_sc_lp  = (settle_cycles_p > check_cycles_p) ? settle_cycles_p : check_cycles_p;
  localparam int cnt_max_lp = (cnt_sc_lp > taps_lp) ? cnt_sc_lp : taps_lp;
  localparam int cnt_w_lp   = (cnt_max_lp > 1) ? $clog2(cnt_max_lp) : 1;
  localparam int len_w_lp   = $clog2(taps_lp + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, CHECK, ANALYZE, APPLY, DONE} state_e;

  state_e                  state_r, state_n;
  logic [cnt_w_lp-1:0]     cnt_r;
  logic [sel_width_p-1:0]  tap_r;
  logic [sel_width_p-1:0]  tap_inc;
  logic [sel_width_p-1:0]  ana_tap;

  logic [taps_lp-1:0]      pass_r       [width_p];
  logic [sel_width_p-1:0]  run_start_r  [width_p];
  logic [sel_width_p-1:0]  best_start_r [width_p];
  logic [len_w_lp-1:0]     run_len_r    [width_p];
  logic [len_w_lp-1:0]     best_len_r   [width_p];
  logic [sel_width_p-1:0]  ext_start    [width_p];
  logic [len_w_lp-1:0]     ext_len      [width_p];

  logic [width_p*sel_width_p-1:0] sel_apply;
  logic [width_p-1:0]             fail_apply;

  logic idle_or_done, start_ok, ovr_ok;
  logic settle_last, check_last, analyze_last, tap_last;

  // Floor centre of a window: start + (len-1)/2.
  function automatic logic [sel_width_p-1:0] centre_sel(input logic [sel_width_p-1:0] start,
                                                        input logic [len_w_lp-1:0]    len);
    return start + sel_width_p'((len - len_w_lp'(1)) >> 1);
  endfunction

  assign idle_or_done = (state_r == IDLE) || (state_r == DONE);
  assign start_ok     = start_i && idle_or_done;
  assign ovr_ok       = override_v_i && idle_or_done && !start_i;
  assign settle_last  = (cnt_r == cnt_w_lp'(settle_cycles_p - 1));
  assign check_last   = (cnt_r == cnt_w_lp'(check_cycles_p - 1));
  assign analyze_last = (cnt_r == cnt_w_lp'(taps_lp - 1));
  assign tap_last     = (tap_r == {sel_width_p{1'b1}});
  assign tap_inc      = tap_r + sel_width_p'(1);
  assign ana_tap      = cnt_r[sel_width_p-1:0];

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE, DONE: if (start_i)      state_n = SETTLE;
      SETTLE:     if (settle_last)  state_n = CHECK;
      CHECK:      if (check_last)   state_n = tap_last ? ANALYZE : SETTLE;
      ANALYZE:    if (analyze_last) state_n = APPLY;
      APPLY:                        state_n = DONE;
      default:                      state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      tap_r   <= '0;
      sel_o   <= '0;
      fail_o  <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_o  <= state_r inside {SETTLE, CHECK, ANALYZE, APPLY};
      done_o  <= (state_r == DONE) && !start_i;

      if (state_n != state_r)
        cnt_r <= '0;
      else if (state_r inside {SETTLE, CHECK, ANALYZE})
        cnt_r <= cnt_r + cnt_w_lp'(1);

      if (start_ok)
        tap_r <= '0;
      else if (state_r == CHECK && check_last && !tap_last)
        tap_r <= tap_inc;

      if (start_ok)
        sel_o <= '0;
      else if (ovr_ok)
        sel_o <= override_sel_i;
      else if (state_r == CHECK && check_last && !tap_last)
        sel_o <= {width_p{tap_inc}};
      else if (state_r == APPLY)
        sel_o <= sel_apply;

      if (start_ok)
        fail_o <= '0;
      else if (state_r == APPLY)
        fail_o <= fail_apply;
    end
  end

  // Run-extension candidates for the tap currently being analysed.
  always_comb begin
    for (int k = 0; k < width_p; k++) begin
      ext_len[k]   = run_len_r[k] + len_w_lp'(1);
      ext_start[k] = (run_len_r[k] == '0) ? ana_tap : run_start_r[k];
    end
  end

  always_comb begin
    sel_apply  = '0;
    fail_apply = '0;
    for (int k = 0; k < width_p; k++) begin
      if (best_len_r[k] == '0) begin
        fail_apply[k] = 1'b1;
      end else begin
        sel_apply[k*sel_width_p +: sel_width_p] = centre_sel(best_start_r[k], best_len_r[k]);
      end
    end
  end

  // Pass map and window tracking; cleared at start so no reset is needed.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < width_p; k++) begin
      if (start_ok) begin
        pass_r[k]       <= '1;
        run_len_r[k]    <= '0;
        run_start_r[k]  <= '0;
        best_len_r[k]   <= '0;
        best_start_r[k] <= '0;
      end else if (state_r == CHECK) begin
        if (sample_i[k] != expected_i[k])
          pass_r[k][tap_r] <= 1'b0;
      end else if (state_r == ANALYZE) begin
        if (pass_r[k][ana_tap]) begin
          run_len_r[k]   <= ext_len[k];
          run_start_r[k] <= ext_start[k];
          if (ext_len[k] > best_len_r[k]) begin
            best_len_r[k]   <= ext_len[k];
            best_start_r[k] <= ext_start[k];
          end
        end else begin
          run_len_r[k] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bsg_link_delay_calib_ctrl.sv
// Directed bench for bsg_link_delay_calib_ctrl with a cycle-level behavioural model
// and hand-computed final select/fail expectations for each scenario.
module tb_bsg_link_delay_calib_ctrl;

  localparam int W   = 18;
  localparam int SW  = 2;
  localparam int T   = 4;
  localparam int S   = 16;
  localparam int C   = 64;
  localparam int CYC = S + C;
  localparam int LAT = 1 + T * CYC + T + 1;

  logic          clk = 1'b0;
  logic          reset_n_i, start_i, override_v_i;
  logic [W-1:0]  sample_i, expected_i;
  logic [W*SW-1:0] override_sel_i, sel_o;
  logic          busy_o, done_o;
  logic [W-1:0]  fail_o;

  int vectors    = 0;
  int miscompares = 0;

  bsg_link_delay_calib_ctrl #(
    .width_p(W), .sel_width_p(SW), .settle_cycles_p(S), .check_cycles_p(C)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i),
    .sample_i(sample_i), .expected_i(expected_i),
    .override_v_i(override_v_i), .override_sel_i(override_sel_i),
    .sel_o(sel_o), .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Mismatch injection per scenario, indexed by edges since start was accepted.
  function automatic logic [W-1:0] mask_for(input int tst, input int e);
    logic [W-1:0] m;
    int tp, ph;
    m = '0;
    if (e >= 1 && e <= T * CYC) begin
      tp = (e - 1) / CYC;
      ph = (e - 1) % CYC;
      case (tst)
        3: if (ph == 40) begin
             if (tp == 0 || tp == 3) m[5] = 1'b1;
             if (tp < 3)             m[7] = 1'b1;
           end
        4: if (ph == 40) begin
             m[2] = 1'b1;
             if (tp == 1 || tp == 3) m[0] = 1'b1;
           end
        5: if (e == 2 * CYC) m[9] = 1'b1;
        6: if (ph < S) m[9] = 1'b1;
        default: m = '0;
      endcase
    end
    return m;
  endfunction

  // Behavioural model: outputs derived from elapsed edges since start.
  bit              m_valid = 0, m_run = 0, m_sdone = 0, m_busy = 0, m_done = 0;
  int              m_e = 0;
  logic [W*SW-1:0] m_sel = '0;
  logic [W-1:0]    m_fail = '0;
  bit              m_pass [W][T];

  task automatic model_finalize();
    int bl, bs;
    bit ok;
    for (int k = 0; k < W; k++) begin
      bl = 0; bs = 0;
      for (int a = 0; a < T; a++)
        for (int b = a; b < T; b++) begin
          ok = 1;
          for (int t = a; t <= b; t++) ok &= m_pass[k][t];
          if (ok && (b - a + 1) > bl) begin bl = b - a + 1; bs = a; end
        end
      m_fail[k] = (bl == 0);
      m_sel[k*SW +: SW] = (bl == 0) ? SW'(0) : SW'(bs + (bl - 1) / 2);
    end
  endtask

  always @(posedge clk) begin
    int tp, ph;
    m_valid = 1;
    if (!reset_n_i) begin
      m_run = 0; m_sdone = 0; m_sel = '0; m_fail = '0; m_busy = 0; m_done = 0;
    end else if (m_run) begin
      m_e++;
      if (m_e <= T * CYC) begin
        tp = (m_e - 1) / CYC;
        ph = (m_e - 1) % CYC;
        if (ph >= S)
          for (int k = 0; k < W; k++)
            if (sample_i[k] !== expected_i[k]) m_pass[k][tp] = 0;
        if (ph == CYC - 1 && tp < T - 1)
          for (int k = 0; k < W; k++) m_sel[k*SW +: SW] = SW'(tp + 1);
      end
      m_busy = 1;
      if (m_e == T * CYC + T + 1) begin
        model_finalize();
        m_run = 0;
        m_sdone = 1;
      end
    end else begin
      m_busy = 0;
      if (start_i) begin
        m_run = 1; m_e = 0; m_sel = '0; m_fail = '0; m_done = 0; m_sdone = 0;
        for (int k = 0; k < W; k++)
          for (int t = 0; t < T; t++) m_pass[k][t] = 1;
      end else begin
        m_done = m_sdone;
        if (override_v_i) m_sel = override_sel_i;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("sel_o",  64'(sel_o),  64'(m_sel));
      check("busy_o", 64'(busy_o), 64'(m_busy));
      check("done_o", 64'(done_o), 64'(m_done));
      check("fail_o", 64'(fail_o), 64'(m_fail));
    end
  end

  task automatic tick(input int tst, input int e);
    expected_i = W'($urandom);
    sample_i   = expected_i ^ mask_for(tst, e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int tst, input int n, input int mid_start, input bit with_ovr,
                     output int first_done);
    start_i = 1'b1;
    override_v_i = with_ovr;
    tick(tst, 0);
    start_i = 1'b0;
    override_v_i = 1'b0;
    if (with_ovr) begin
      check("start_beats_override_sel", 64'(sel_o), 64'd0);
      check("start_beats_override_done", 64'(done_o), 64'd0);
    end
    first_done = -1;
    for (int e = 1; e <= n; e++) begin
      start_i = (e == mid_start);
      tick(tst, e);
      if (done_o === 1'b1 && first_done < 0) first_done = e;
    end
    start_i = 1'b0;
  endtask

  initial begin
    int fd;
    reset_n_i = 1'b0; start_i = 1'b0; override_v_i = 1'b0;
    override_sel_i = '0; sample_i = '0; expected_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sel", 64'(sel_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_done", 64'(done_o), 64'd0);
    reset_n_i = 1'b1;
    tick(0, 0);

    // Reset asserted mid-CHECK of tap 0
    run(2, 50, -1, 1'b0, fd);
    check("midcheck_busy", 64'(busy_o), 64'd1);
    reset_n_i = 1'b0;
    tick(0, 0);
    tick(0, 0);
    reset_n_i = 1'b1;
    check("rst_sel", 64'(sel_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_fail", 64'(fail_o), 64'd0);
    tick(0, 0);

    // All clean
    run(2, LAT + 4, -1, 1'b0, fd);
    check("clean_latency", 64'(fd), 64'd326);
    check("clean_sel", 64'(sel_o), 64'h555555555);
    check("clean_fail", 64'(fail_o), 64'd0);

    // Bit5 fails taps 0,3; bit7 passes only tap 3
    run(3, LAT + 4, -1, 1'b0, fd);
    check("t3_sel", 64'(sel_o), 64'h55555D555);
    check("t3_fail", 64'(fail_o), 64'd0);

    // Bit2 fails everywhere; bit0 passes taps 0 and 2
    run(4, LAT + 4, -1, 1'b0, fd);
    check("t4_sel", 64'(sel_o), 64'h555555544);
    check("t4_fail", 64'(fail_o), 64'h4);

    // Single mismatch on bit9 in last check cycle of tap 1
    run(5, LAT + 4, -1, 1'b0, fd);
    check("t5_sel", 64'(sel_o), 64'h555595555);
    check("t5_fail", 64'(fail_o), 64'd0);

    // Bit9 mismatches only while settling
    run(6, LAT + 4, -1, 1'b0, fd);
    check("t5b_sel", 64'(sel_o), 64'h555555555);

    // Start pulse mid-sweep is ignored
    run(2, LAT + 4, 100, 1'b0, fd);
    check("midstart_latency", 64'(fd), 64'd326);

    // Override in DONE keeps done high
    override_sel_i = '1;
    override_v_i = 1'b1;
    tick(0, 0);
    override_v_i = 1'b0;
    check("ovr_sel", 64'(sel_o), 64'hFFFFFFFFF);
    check("ovr_done", 64'(done_o), 64'd1);
    tick(0, 0);

    // Start and override together: start wins
    run(2, LAT + 4, -1, 1'b1, fd);
    check("restart_latency", 64'(fd), 64'd326);
    check("restart_sel", 64'(sel_o), 64'h555555555);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
